// File: rtl/regb_fifo_arb.sv
// Round-robin burst arbiter writing NREQ requesters into one external FIFO; drains it to a consumer.
// Writes start 1 cycle after a grant, are throttled by fifo_full, and the read side is pure combinational pass-through.
module regb_fifo_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int BURST = 4,
  localparam int GW   = $clog2(NREQ),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      fifo_wdata,
  output logic                  fifo_shift_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  fifo_shift_out,
  input  logic [WIDTH-1:0]      fifo_rdata,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic [LW-1:0]         level
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr, rr_d;
  logic [GW-1:0]   grant_d;
  logic [3:0]      burst_cnt, cnt_d;
  logic            sel_found;
  logic [GW-1:0]   sel_idx;
  logic            gvalid;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  assign gvalid     = req_valid[grant_id];
  assign fifo_wdata = req_data[int'(grant_id)*WIDTH +: WIDTH];

  always_comb begin
    req_ready     = '0;
    fifo_shift_in = 1'b0;
    busy          = 1'b0;
    state_d       = state_q;
    grant_d       = grant_id;
    cnt_d         = burst_cnt;
    rr_d          = rr_ptr;
    if (!res && state_q == ST_BURST) begin
      busy                = 1'b1;
      req_ready[grant_id] = !fifo_full;
      fifo_shift_in       = gvalid && !fifo_full;
    end
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_BURST;
          grant_d = sel_idx;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (fifo_shift_in) cnt_d = burst_cnt + 4'd1;
        if ((fifo_shift_in && cnt_d == 4'(BURST)) || !gvalid ||
            (fifo_full && level == LW'(DEPTH))) begin
          state_d = ST_IDLE;
          rr_d    = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid      = !fifo_empty;
  assign out_data       = fifo_rdata;
  assign fifo_shift_out = out_valid && out_ready;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
      level     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_d;
      burst_cnt <= cnt_d;
      grant_id  <= grant_d;
      // Occupancy mirror; saturates rather than wrapping.
      if (fifo_shift_in && !fifo_shift_out && level != LW'(DEPTH))
        level <= level + LW'(1);
      else if (fifo_shift_out && !fifo_shift_in && level != '0)
        level <= level - LW'(1);
    end
  end

endmodule

// File: tb/tb_regb_fifo_arb.sv
// Bench for regb_fifo_arb: behavioural FIFO, counting requesters, queued expected writes/reads.
module tb_regb_fifo_arb;
  localparam int NREQ = 4, WIDTH = 8, DEPTH = 5, BURST = 4;

  logic                  clk = 1'b0;
  logic                  res;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      fifo_wdata, fifo_rdata, out_data;
  logic                  fifo_shift_in, fifo_shift_out, fifo_full, fifo_empty;
  logic                  out_valid, out_ready, busy;
  logic [1:0]            grant_id;
  logic [2:0]            level;

  int rem[NREQ];
  int cnt[NREQ];
  logic [31:0] exp_w[$];
  logic [31:0] exp_o[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regb_fifo_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .res(res), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wdata(fifo_wdata), .fifo_shift_in(fifo_shift_in), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_shift_out(fifo_shift_out), .fifo_rdata(fifo_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .level(level));

  // External FIFO model
  logic [WIDTH-1:0] mem[DEPTH];
  int fcnt, fhead;
  always @(posedge clk or posedge res) begin
    if (res) begin
      fcnt  <= 0;
      fhead <= 0;
    end else begin
      int nc;
      nc = fcnt;
      if (fifo_shift_in && fcnt < DEPTH) begin
        mem[(fhead + fcnt) % DEPTH] <= fifo_wdata;
        nc++;
      end
      if (fifo_shift_out && fcnt > 0) begin
        fhead <= (fhead + 1) % DEPTH;
        nc--;
      end
      fcnt <= nc;
    end
  end
  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);
  assign fifo_rdata = mem[fhead];

  // Requester i offers {i, sequence number} while it has words left.
  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = rem[i] > 0;
      req_data[i*WIDTH +: WIDTH] = 8'(i * 16 + cnt[i]);
    end
  end

  always begin
    logic [NREQ-1:0] hs;
    @(negedge clk);
    #3;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs[i]) begin
        rem[i] = rem[i] - 1;
        cnt[i] = cnt[i] + 1;
      end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int id, input int c);
    logic [7:0] d;
    d = 8'(id * 16 + c);
    exp_w.push_back({22'd0, 2'(id), d});
    exp_o.push_back({24'd0, d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_w.size() == 0 && exp_o.size() == 0) break;
    end
    chk(name, 32'(exp_w.size() + exp_o.size()), 0);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
    end
  endtask

  // Monitor: every write and every consumer read is matched against the queues.
  always begin
    logic [31:0] e;
    @(negedge clk);
    #3;
    if (fifo_shift_in) begin
      chk("no_write_while_full", {31'd0, fifo_full}, 0);
      if (exp_w.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got gid=%0d data=%0h, expected none", grant_id, fifo_wdata);
      end else begin
        e = exp_w.pop_front();
        chk("write_gid_data", {22'd0, grant_id, fifo_wdata}, e);
      end
    end
    if (out_valid && out_ready) begin
      chk("shift_out", {31'd0, fifo_shift_out}, 1);
      if (exp_o.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %0h, expected none", out_data);
      end else begin
        e = exp_o.pop_front();
        chk("out_data", {24'd0, out_data}, e);
      end
    end
  end

  initial begin
    bit seen;
    res = 1'b1;
    out_ready = 1'b0;
    clear_reqs();

    // Two requesters 0 and 2: bursts of 4, then back to 0
    rem[0] = 5;
    rem[2] = 4;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) push(0, c);
    for (int c = 0; c < 4; c++) push(2, c);
    push(0, 4);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_shift_in", {31'd0, fifo_shift_in}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_grant_id", {30'd0, grant_id}, 0);
    res = 1'b0;
    #1 chk("idle_req_ready", {28'd0, req_ready}, 0);
    @(posedge clk);
    #1;
    chk("first_grant", {30'd0, grant_id}, 0);
    chk("first_busy", {31'd0, busy}, 1);
    chk("first_req_ready", {28'd0, req_ready}, 4'b0001);
    wait_drain("drain_a", 60);
    chk("level_a_end", {29'd0, level}, 0);

    // All four valid: 0,1,2,3,0,1,2,3, four words each
    @(negedge clk);
    res = 1'b1;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) rem[i] = 8;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int c = 0; c < 4; c++) push(i, r * 4 + c);
    repeat (2) @(negedge clk);
    res = 1'b0;
    wait_drain("drain_b", 200);

    // Consumer stalled: fill to DEPTH, then single-word reads
    @(negedge clk);
    res = 1'b1;
    clear_reqs();
    out_ready = 1'b0;
    rem[0] = 6;
    for (int c = 0; c < 6; c++) push(0, c);
    repeat (2) @(negedge clk);
    res = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("full_level", {29'd0, level}, 5);
    chk("full_flag", {31'd0, fifo_full}, 1);
    chk("full_req_ready", {28'd0, req_ready}, 0);
    chk("full_write_count", 32'(exp_w.size()), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("level_after_read", {29'd0, level}, 4);
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("refill_write", 32'(exp_w.size()), 0);
    chk("refill_level", {29'd0, level}, 5);
    chk("refill_full", {31'd0, fifo_full}, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("level_three", {29'd0, level}, 3);
    @(negedge clk);
    rem[1] = 1;
    push(1, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (fifo_shift_in) begin
        out_ready = 1'b1;
        seen = 1'b1;
        break;
      end
    end
    chk("simul_write_seen", {31'd0, seen}, 1);
    @(posedge clk);
    #1;
    chk("simul_level", {29'd0, level}, 3);
    out_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain("drain_c", 30);
    chk("level_c_end", {29'd0, level}, 0);

    // Reset in the middle of requester 2's burst
    @(negedge clk);
    res = 1'b1;
    clear_reqs();
    rem[2] = 10;
    push(2, 0);
    push(2, 1);
    repeat (2) @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exp_w.size() == 0) break;
    end
    chk("pre_abort_grant", {30'd0, grant_id}, 2);
    res = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_req_ready", {28'd0, req_ready}, 0);
    chk("abort_shift_in", {31'd0, fifo_shift_in}, 0);
    chk("abort_level", {29'd0, level}, 0);
    chk("abort_grant_id", {30'd0, grant_id}, 0);
    exp_o.delete();
    clear_reqs();
    rem[1] = 1;
    rem[3] = 1;
    push(1, 0);
    push(3, 0);
    repeat (2) @(negedge clk);
    res = 1'b0;
    #1 chk("post_rst_level", {29'd0, level}, 0);
    wait_drain("drain_d", 30);
    chk("level_d_end", {29'd0, level}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
